ip_stream_tx: RTL

- Transmit-side companion to the relinearization inner-product engine.
- Holds one ciphertext polynomial (1024 coefficients x 30 bits), loaded through a write port.
- On request, drives the engine's start/cipher/rlk input stream: a one-cycle start, then 1024 cipher words, then 1024x30 rlk words fetched from an external key memory.
- Sits between the host/key store and the inner-product engine; emits one word per cycle with no backpressure.

---
 rtl/ip_stream_pkg.sv | 33 +++
 rtl/ip_stream_tx_if.sv | 47 ++++
 rtl/ip_cipher_buf.sv | 40 ++++
 rtl/ip_stream_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ip_stream_pkg.sv
// -----------------------------------------------------------------------------
// ip_stream_pkg
// Shared constants and the state type for the ip_stream_tx transmit block.
//   N          coefficients per polynomial
//   W          coefficient / stream word width
//   L          rlk words per coefficient (one per decomposition bit)
//   KEY_WORDS  rlk words per transfer (N*L)
// Optional feature macro used by the importing files: IP_STREAM_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package ip_stream_pkg;

   localparam int N         = 1024;
   localparam int W         = 30;
   localparam int L         = 30;
   localparam int KEY_WORDS = N * L;

   localparam int BUF_AW = $clog2(N);
   localparam int KEY_AW = $clog2(KEY_WORDS);

   // Cipher index of the last and next-to-last SEND_C cycles, and last key address.
   localparam logic [BUF_AW-1:0] CNT_LAST    = BUF_AW'(N - 1);
   localparam logic [BUF_AW-1:0] CNT_PRELAST = BUF_AW'(N - 2);
   localparam logic [KEY_AW-1:0] ADDR_LAST   = KEY_AW'(KEY_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      SEND_C = 3'd2,
      SEND_K = 3'd3,
      FIN    = 3'd4
   } state_e;

endpackage

// File: rtl/ip_stream_tx_if.sv
// -----------------------------------------------------------------------------
// ip_stream_tx_if
// Groups the host write port, key-memory read port and engine stream of
// ip_stream_tx.
//   master : view of ip_stream_tx itself
//   slave  : view of the surroundings (host, key store, engine)
// With IP_STREAM_CHECKSUM_EN defined, stream_sum (mod-2^W sum of every word
// streamed) is added.
// -----------------------------------------------------------------------------
interface ip_stream_tx_if;
   import ip_stream_pkg::*;

   logic              go;
   logic              buf_wr_en;
   logic [BUF_AW-1:0] buf_wr_addr;
   logic [W-1:0]      buf_wr_data;
   logic              rlk_rd_en;
   logic [KEY_AW-1:0] rlk_rd_addr;
   logic [W-1:0]      rlk_rd_data;
   logic              start;
   logic [W-1:0]      cipher;
   logic [W-1:0]      rlk;
   logic              busy;
   logic              done;
`ifdef IP_STREAM_CHECKSUM_EN
   logic [W-1:0]      stream_sum;

   modport master (
      input  go, buf_wr_en, buf_wr_addr, buf_wr_data, rlk_rd_data,
      output rlk_rd_en, rlk_rd_addr, start, cipher, rlk, busy, done, stream_sum
   );
   modport slave (
      output go, buf_wr_en, buf_wr_addr, buf_wr_data, rlk_rd_data,
      input  rlk_rd_en, rlk_rd_addr, start, cipher, rlk, busy, done, stream_sum
   );
`else
   modport master (
      input  go, buf_wr_en, buf_wr_addr, buf_wr_data, rlk_rd_data,
      output rlk_rd_en, rlk_rd_addr, start, cipher, rlk, busy, done
   );
   modport slave (
      output go, buf_wr_en, buf_wr_addr, buf_wr_data, rlk_rd_data,
      input  rlk_rd_en, rlk_rd_addr, start, cipher, rlk, busy, done
   );
`endif

endinterface

// File: rtl/ip_cipher_buf.sv
// -----------------------------------------------------------------------------
// ip_cipher_buf
// Simple dual-port N x W RAM holding one ciphertext polynomial.
//   clk, rst_n          clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data   write port, written at the rising edge
//   rd_en/rd_addr       read request
//   rd_data             registered read data, 1-cycle latency; holds its value
//                       while rd_en is low
// -----------------------------------------------------------------------------
module ip_cipher_buf
   import ip_stream_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [BUF_AW-1:0] wr_addr,
   input  logic [W-1:0]      wr_data,
   input  logic              rd_en,
   input  logic [BUF_AW-1:0] rd_addr,
   output logic [W-1:0]      rd_data
);

   logic [W-1:0] mem [N];
   logic [W-1:0] rd_data_q;

   // NOTE: the storage array has no reset so it maps onto block RAM; only the
   // read register below is reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // NOTE: sequential state is always assigned with non-blocking (<=).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data_q <= '0;
      else if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ip_stream_tx.sv
// -----------------------------------------------------------------------------
// ip_stream_tx
// Transmit-side feeder for the relinearization inner-product engine. Holds one
// cipher polynomial and, on go, emits: one start cycle, N cipher words, then
// KEY_WORDS rlk words fetched from the external key memory, then a done pulse.
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    ip_stream_tx_if.master: go, buffer write port, key read port
//          (rlk_rd_en/addr out, rlk_rd_data in 1 cycle later), start, cipher,
//          rlk, busy, done
// Optional: `define IP_STREAM_CHECKSUM_EN adds bus.stream_sum, the mod-2^W sum
// of all streamed words, cleared at START and valid from done onward.
// -----------------------------------------------------------------------------
module ip_stream_tx
   import ip_stream_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   ip_stream_tx_if.master bus
);

   state_e            state_q, state_d;
   logic [BUF_AW-1:0] cnt_q, cnt_d;     // cipher index k while in SEND_C
   logic [KEY_AW-1:0] addr_q, addr_d;   // key memory read address
   logic              rd_en_q, rd_en_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              buf_wr_en;
   logic              buf_rd_en;
   logic [BUF_AW-1:0] buf_rd_addr;
   logic [W-1:0]      buf_rd_data;

   // Writes are only taken while not busy, so a stream never mixes old and new data.
   assign buf_wr_en = bus.buf_wr_en && !busy_q;

   ip_cipher_buf u_buf (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (buf_wr_en),
      .wr_addr (bus.buf_wr_addr),
      .wr_data (bus.buf_wr_data),
      .rd_en   (buf_rd_en),
      .rd_addr (buf_rd_addr),
      .rd_data (buf_rd_data)
   );

   // Buffer read is issued one cycle ahead of the cipher word it produces.
   always_comb begin
      buf_rd_en   = 1'b0;
      buf_rd_addr = '0;
      if (state_q == START) begin
         buf_rd_en = 1'b1;
      end else if (state_q == SEND_C && cnt_q != CNT_LAST) begin
         buf_rd_en   = 1'b1;
         buf_rd_addr = cnt_q + BUF_AW'(1);
      end
   end

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_en_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            addr_d = '0;
            if (bus.go) state_d = START;
         end
         START: begin
            cnt_d   = '0;
            state_d = SEND_C;
         end
         SEND_C: begin
            cnt_d = cnt_q + BUF_AW'(1);
            // Key read for word 0 goes out in the last cipher cycle, so the
            // first rlk word lands directly after the last cipher word.
            if (cnt_q == CNT_PRELAST) rd_en_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
               rd_en_d = 1'b1;
               addr_d  = KEY_AW'(1);
               state_d = SEND_K;
            end
         end
         SEND_K: begin
            // A cycle with no read outstanding is the one carrying the last word.
            if (!rd_en_q) begin
               state_d = FIN;
            end else if (addr_q != ADDR_LAST) begin
               rd_en_d = 1'b1;
               addr_d  = addr_q + KEY_AW'(1);
            end
         end
         FIN: begin
            addr_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Status outputs are registered images of the next state.
   assign start_d = (state_d == START);
   assign busy_d  = (state_d == START) || (state_d == SEND_C) || (state_d == SEND_K);
   assign done_d  = (state_d == FIN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_en_q <= rd_en_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.rlk_rd_en   = rd_en_q;
   assign bus.rlk_rd_addr = addr_q;
   assign bus.start       = start_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   // The buffer's read register is the cipher output register; it holds the
   // last word once SEND_C ends.
   assign bus.cipher      = buf_rd_data;
   // The key memory's output register feeds rlk; gating by the state flop
   // forces 0 outside SEND_K.
   assign bus.rlk         = (state_q == SEND_K) ? bus.rlk_rd_data : '0;

`ifdef IP_STREAM_CHECKSUM_EN
   logic [W-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (state_q == IDLE && bus.go) sum_d = '0;
      else if (state_q == SEND_C)    sum_d = sum_q + bus.cipher;
      else if (state_q == SEND_K)    sum_d = sum_q + bus.rlk;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sum_q <= '0;
      else        sum_q <= sum_d;
   end

   assign bus.stream_sum = sum_q;
`endif

endmodule
